fft_butterfly_engine: RTL and testbench
=======================================

# fft_butterfly_engine

- In-place radix-2 decimation-in-time FFT engine for the complex sample memory.
- Drives the memory's two read ports and single write port: reads each butterfly operand pair, fetches the twiddle from an external combinational ROM, and writes both results back to the same addresses.
- The upstream loader leaves N = 2^A_LEN samples in bit-reversed order; when `done` pulses, memory holds the natural-order DFT.

## Interface
- `W`, 16: bits per real/imag component; a complex word is 2W bits, {re, im}, signed two's complement.
- `A_LEN`, 5: address width; N = 2^A_LEN points, A_LEN stages.
- `clk` in 1: clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: one-cycle request to run a full FFT; sampled only in IDLE.
- `raddr1` out A_LEN: read address of operand A (top).
- `raddr2` out A_LEN: read address of operand B (bottom).
- `rdata1` in 2W: combinational memory data at `raddr1`.
- `rdata2` in 2W: combinational memory data at `raddr2`.
- `tw_addr` out A_LEN-1: twiddle index k; ROM returns W_N^k = exp(-j2πk/N).
- `tw_data` in 2W: combinational ROM data, components Q1.(W-2), so +1.0 = 2^(W-2).
- `waddr` out A_LEN: registered write address.
- `wdata` out 2W: registered write data.
- `we` out 1: registered write strobe.
- `busy` out 1: high while an FFT is in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- Reset or IDLE: every output is 0; stage counter s = 0; butterfly counter k = 0.
- FSM states: IDLE, RD, WA, WB, DONE.
- IDLE→RD on `start`. RD→WA→WB unconditionally.
- WB→RD while butterflies remain; WB→DONE after the last butterfly of stage A_LEN-1. DONE→IDLE.
- Addressing in RD, for stage s and butterfly k in 0..N/2-1:
  - span = 2^s; pos = k & (span-1); grp = k >> s.
  - a = (grp << (s+1)) | pos; b = a + span; tw = pos << (A_LEN-1-s).
  - `raddr1` = a, `raddr2` = b, `tw_addr` = tw.
- Order: k increments after each WB; at k = N/2-1 it wraps to 0 and s increments.
- RD latches A = `rdata1`, B = `rdata2`, T = `tw_data`, then computes:
  - P = B·T. Each component is a full 2W+1-bit signed sum of products, arithmetic-shifted right by W-2, then truncated to W bits.
  - X = A + P; Y = A − P.
- WA: `we`=1, `waddr`=a, `wdata`=X. WB: `we`=1, `waddr`=b, `wdata`=Y.
- `we`=0 in every other state.
- Consecutive writes never target the same address: b has bit s set, and the next a has it clear; across stages, N-1 is followed by 0. Memories that latch on address change therefore see every write.
- In-place safety: both operands are latched in RD before either write.
- Overflow without scaling: sums wrap in W-bit two's complement.

## Timing
- `start` is sampled at edge 0; the first RD is cycle 1.
- Each butterfly takes 3 cycles; the full run takes 3·A_LEN·N/2 cycles (240 for defaults).
- DONE is cycle 3·A_LEN·N/2 + 1: `done`=1 for exactly that cycle, and `busy` drops in the following cycle.
- `busy`=1 in RD, WA, WB and DONE.
- `start` while busy is ignored; it is neither queued nor restarts the run.
- `start` in the DONE cycle is ignored. `start` on the cycle after DONE begins a new run.
- `rst` mid-run: immediate return to IDLE with all outputs 0. Memory contents are undefined; a partially written stage is not undone.

## Configuration
- `FFT_SCALE_EN` defined: X and Y are computed at W+1 bits, then arithmetic-shifted right by 1 (truncation) before writing. Total scaling is 1/N, and the result cannot overflow.
- `FFT_SCALE_EN` undefined: no per-stage scaling; W-bit wrap as described in Operation.

## Test plan
- Impulse, W=16, N=32: mem[0] = {0x0100, 0}, all other words 0. Required: all 32 words {0x0100, 0}. With `FFT_SCALE_EN`: all words {0x0008, 0}.
- DC input: all words {0x0100, 0}. Required: mem[0] = {0x2000, 0}, all others 0. With `FFT_SCALE_EN`: mem[0] = {0x0100, 0}.
- Address/twiddle trace:
  - Stage 0 pairs (0,1), (2,3), … all with tw=0.
  - Stage 4 pairs (0,16) tw=0, (1,17) tw=1, …, (15,31) tw=15.
  - `we` pattern 0,1,1 per butterfly; no two consecutive writes share an address.
- Handshake: `start` at cycle 0 gives `busy`=1 at cycle 1 and `done`=1 only at cycle 241. `start` pulses at cycles 50 and 241 are ignored; a `start` at cycle 242 runs again.
- Reset mid-run: assert `rst` at cycle 100. All outputs are 0 within the same cycle, state is IDLE, and a later `start` produces a correct impulse result after reloading memory.

Source files
------------

// File: rtl/fft_butterfly_engine.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per three cycles (RD, WA, WB) over A_LEN stages.
// Define FFT_SCALE_EN to halve every butterfly output, which scales the whole transform by 1/N.
module fft_butterfly_engine #(
  parameter int W     = 16,
  parameter int A_LEN = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [A_LEN-1:0]   raddr1,
  output logic [A_LEN-1:0]   raddr2,
  input  logic [2*W-1:0]     rdata1,
  input  logic [2*W-1:0]     rdata2,
  output logic [A_LEN-2:0]   tw_addr,
  input  logic [2*W-1:0]     tw_data,
  output logic [A_LEN-1:0]   waddr,
  output logic [2*W-1:0]     wdata,
  output logic               we,
  output logic               busy,
  output logic               done
);

  localparam int SW = (A_LEN > 1) ? $clog2(A_LEN) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WA   = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [SW-1:0]    LAST_S = SW'(A_LEN - 1);
  localparam logic [A_LEN-2:0] K_LAST = {(A_LEN-1){1'b1}};
  localparam logic [A_LEN-1:0] ONE_A  = {{(A_LEN-1){1'b0}}, 1'b1};

  // Operand A address: insert a zero at bit position s of the butterfly index.
  function automatic logic [A_LEN-1:0] addr_a(input logic [SW-1:0] s, input logic [A_LEN-2:0] k);
    logic [A_LEN-1:0] kx;
    logic [A_LEN-1:0] lo_mask;
    kx      = {1'b0, k};
    lo_mask = (ONE_A << s) - ONE_A;
    return ((kx & ~lo_mask) << 1) | (kx & lo_mask);
  endfunction

  function automatic logic [A_LEN-1:0] addr_b(input logic [SW-1:0] s, input logic [A_LEN-2:0] k);
    return addr_a(s, k) | (ONE_A << s);
  endfunction

  function automatic logic [A_LEN-2:0] addr_tw(input logic [SW-1:0] s, input logic [A_LEN-2:0] k);
    logic [A_LEN-1:0] lo_mask;
    logic [A_LEN-2:0] pos;
    lo_mask = (ONE_A << s) - ONE_A;
    pos     = k & lo_mask[A_LEN-2:0];
    return pos << (LAST_S - s);
  endfunction

  // B*T with each component formed at 2W+1 bits, then rescaled from Q1.(W-2).
  function automatic logic [2*W-1:0] cmul(input logic [2*W-1:0] b, input logic [2*W-1:0] t);
    logic signed [2*W:0] br, bi, tr, ti, pr, pi;
    br = {{(W+1){b[2*W-1]}}, b[2*W-1:W]};
    bi = {{(W+1){b[W-1]}},   b[W-1:0]};
    tr = {{(W+1){t[2*W-1]}}, t[2*W-1:W]};
    ti = {{(W+1){t[W-1]}},   t[W-1:0]};
    pr = (br * tr) - (bi * ti);
    pi = (br * ti) + (bi * tr);
    pr = pr >>> (W - 2);
    pi = pi >>> (W - 2);
    return {pr[W-1:0], pi[W-1:0]};
  endfunction

  function automatic logic [W-1:0] badd(input logic [W-1:0] a, input logic [W-1:0] p, input logic sub);
`ifdef FFT_SCALE_EN
    logic [W:0] ax, px, r;
    ax = {a[W-1], a};
    px = {p[W-1], p};
    r  = sub ? (ax - px) : (ax + px);
    return r[W:1];
`else
    return sub ? (a - p) : (a + p);
`endif
  endfunction

  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [A_LEN-2:0] k_q, k_d;
  logic [2*W-1:0]   y_q, y_d;
  logic [A_LEN-1:0] raddr1_q, raddr1_d, raddr2_q, raddr2_d, waddr_q, waddr_d;
  logic [A_LEN-2:0] tw_q, tw_d;
  logic [2*W-1:0]   wdata_q, wdata_d;
  logic             we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [2*W-1:0]   p_s, x_s, y_s;

  assign p_s = cmul(rdata2, tw_data);
  assign x_s = {badd(rdata1[2*W-1:W], p_s[2*W-1:W], 1'b0), badd(rdata1[W-1:0], p_s[W-1:0], 1'b0)};
  assign y_s = {badd(rdata1[2*W-1:W], p_s[2*W-1:W], 1'b1), badd(rdata1[W-1:0], p_s[W-1:0], 1'b1)};

  // Sequencing: state, stage/butterfly counters and the held bottom result.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        s_d = '0;
        k_d = '0;
        if (start) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        y_d     = y_s;
        state_d = ST_WA;
      end
      ST_WA: state_d = ST_WB;
      ST_WB: begin
        if (k_q == K_LAST) begin
          k_d = '0;
          if (s_q == LAST_S) begin
            s_d     = '0;
            state_d = ST_DONE;
          end else begin
            s_d     = s_q + {{(SW-1){1'b0}}, 1'b1};
            state_d = ST_RD;
          end
        end else begin
          k_d     = k_q + {{(A_LEN-2){1'b0}}, 1'b1};
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        k_d     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    raddr1_d = '0;
    raddr2_d = '0;
    tw_d     = '0;
    waddr_d  = '0;
    wdata_d  = '0;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      ST_RD: begin
        raddr1_d = addr_a(s_d, k_d);
        raddr2_d = addr_b(s_d, k_d);
        tw_d     = addr_tw(s_d, k_d);
        busy_d   = 1'b1;
      end
      ST_WA: begin
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        tw_d     = tw_q;
        waddr_d  = raddr1_q;
        wdata_d  = x_s;
        we_d     = 1'b1;
        busy_d   = 1'b1;
      end
      ST_WB: begin
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        tw_d     = tw_q;
        waddr_d  = raddr2_q;
        wdata_d  = y_q;
        we_d     = 1'b1;
        busy_d   = 1'b1;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      k_q      <= '0;
      y_q      <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      tw_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      y_q      <= y_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      tw_q     <= tw_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign raddr1  = raddr1_q;
  assign raddr2  = raddr2_q;
  assign tw_addr = tw_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign we      = we_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fft_butterfly_engine.sv
// Directed bench for fft_butterfly_engine: memory and twiddle ROM models, address trace,
// handshake timing, impulse/DC transforms and mid-run reset.
module tb_fft_butterfly_engine;
  localparam int W = 16;
  localparam int A = 5;
  localparam int N = 32;
  localparam int HALF = 16;
  localparam int RUN = 240;
`ifdef FFT_SCALE_EN
  localparam logic [W-1:0] IMP_OUT = 16'h0008;
  localparam logic [W-1:0] DC_OUT  = 16'h0100;
`else
  localparam logic [W-1:0] IMP_OUT = 16'h0100;
  localparam logic [W-1:0] DC_OUT  = 16'h2000;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [A-1:0] raddr1, raddr2, waddr;
  logic [A-2:0] tw_addr;
  logic [2*W-1:0] rdata1, rdata2, tw_data, wdata;
  logic we, busy, done;

  logic [2*W-1:0] mem [N];
  logic [2*W-1:0] tw_rom [HALF];
  logic ld_we;
  logic [A-1:0] ld_addr;
  logic [2*W-1:0] ld_data;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_butterfly_engine #(.W(W), .A_LEN(A)) dut (
    .clk(clk), .rst(rst), .start(start),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .tw_addr(tw_addr), .tw_data(tw_data),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy), .done(done)
  );

  assign rdata1  = mem[raddr1];
  assign rdata2  = mem[raddr2];
  assign tw_data = tw_rom[tw_addr];

  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    else if (ld_we) mem[ld_addr] <= ld_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic load(input bit dc);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ld_we = 1'b1;
      ld_addr = A'(i);
      ld_data = (dc || i == 0) ? {16'h0100, 16'h0000} : 32'h0;
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [2*W-1:0] e0, input logic [2*W-1:0] erest);
    int bad = 0;
    for (int i = 1; i < N; i++) if (mem[i] !== erest) bad++;
    check({tag, "_w0"}, mem[0], e0);
    check({tag, "_rest_bad"}, bad, 0);
  endtask

  // One full run from a start pulse; hs adds the ignored/accepted start pulses.
  task automatic run(input bit hs);
    int cyc, bf, ph, s, k, span, ea, eb, et;
    int trace_bad = 0, same_wr = 0, done_seen = 0, done_at = -1;
    bit have_last = 1'b0;
    bit got;
    logic [A-1:0] last_w = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= RUN + 2) begin
      if (cyc == 1) check("busy_c1", busy, 1);
      if (cyc <= RUN) begin
        bf = (cyc - 1) / 3; ph = (cyc - 1) % 3;
        s = bf / HALF; k = bf % HALF; span = 1 << s;
        ea = k + (k & ~(span - 1)); eb = ea + span;
        et = (k & (span - 1)) << (A - 1 - s);
        if (ph == 0) begin
          if (we !== 1'b0 || int'(raddr1) != ea || int'(raddr2) != eb || int'(tw_addr) != et) trace_bad++;
        end else if (ph == 1) begin
          if (we !== 1'b1 || int'(waddr) != ea) trace_bad++;
        end else begin
          if (we !== 1'b1 || int'(waddr) != eb) trace_bad++;
        end
      end
      if (cyc == 1)   check("s0_bf0",  {raddr1, raddr2, tw_addr}, {5'd0, 5'd1, 4'd0});
      if (cyc == 4)   check("s0_bf1",  {raddr1, raddr2, tw_addr}, {5'd2, 5'd3, 4'd0});
      if (cyc == 193) check("s4_bf0",  {raddr1, raddr2, tw_addr}, {5'd0, 5'd16, 4'd0});
      if (cyc == 196) check("s4_bf1",  {raddr1, raddr2, tw_addr}, {5'd1, 5'd17, 4'd1});
      if (cyc == 238) check("s4_bf15", {raddr1, raddr2, tw_addr}, {5'd15, 5'd31, 4'd15});
      if (we) begin
        if (have_last && waddr == last_w) same_wr++;
        last_w = waddr;
        have_last = 1'b1;
      end
      if (done) begin
        done_seen++;
        done_at = cyc;
      end
      if (cyc == RUN + 1) check("busy_in_done", busy, 1);
      if (cyc == RUN + 2) check("busy_drop", busy, 0);
      start = hs && (cyc == 50 || cyc == RUN + 1 || cyc == RUN + 2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_cycle", done_at, RUN + 1);
    check("done_count", done_seen, 1);
    check("trace_bad", trace_bad, 0);
    check("same_wr_addr", same_wr, 0);
    if (hs) begin
      check("restart_busy", busy, 1);
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      check("restart_done", got, 1);
      @(negedge clk);
    end
  endtask

  initial begin
    real ang;
    rst = 1'b1; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < HALF; i++) begin
      ang = 2.0 * 3.14159265358979 * i / N;
      tw_rom[i] = {16'(rnd($cos(ang) * 16384.0)), 16'(rnd(-$sin(ang) * 16384.0))};
    end
    repeat (3) @(negedge clk);
    check("rst_outs", {raddr1, raddr2, tw_addr, waddr, we, busy, done, wdata}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", {raddr1, raddr2, tw_addr, waddr, we, busy, done, wdata}, 64'h0);

    load(1'b0);
    run(1'b0);
    check_mem("impulse", {IMP_OUT, 16'h0}, {IMP_OUT, 16'h0});

    load(1'b1);
    run(1'b0);
    check_mem("dc", {DC_OUT, 16'h0}, 32'h0);

    run(1'b1);

    load(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_outs", {raddr1, raddr2, tw_addr, waddr, we, busy, done, wdata}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, we, done}, 3'b000);
    load(1'b0);
    run(1'b0);
    check_mem("impulse_after_rst", {IMP_OUT, 16'h0}, {IMP_OUT, 16'h0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
